// File: rtl/cordic_pkg.sv
// Shared constants, FSM state type and repeat-index helper for the CORDIC iteration sequencer.
// Hyperbolic support is controlled by the CORDIC_HYP_EN macro.
package cordic_pkg;

    localparam logic MODE_CIRC = 1'b0;
    localparam logic MODE_HYP  = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    localparam int NREP     = 3;
    localparam int REP_IDX0 = 4;
    localparam int REP_IDX1 = 13;
    localparam int REP_IDX2 = 40;

    // One-hot match of idx against the repeat indices that exist at this depth
    function automatic logic [NREP-1:0] rep_hit(int idx, int max_iter);
        logic [NREP-1:0] hit;
        hit[0] = (idx == REP_IDX0) && (REP_IDX0 < max_iter);
        hit[1] = (idx == REP_IDX1) && (REP_IDX1 < max_iter);
        hit[2] = (idx == REP_IDX2) && (REP_IDX2 < max_iter);
        return hit;
    endfunction

endpackage

// File: rtl/cordic_iter_seq_if.sv
// Control/status bundle between the CORDIC control FSM (master)
// and the iteration sequencer (slave).
interface cordic_iter_seq_if #(
    parameter int CW = 5
);
    logic          start;
    logic [CW-1:0] n_iter;
    logic          mode;
    logic          stall;
    logic          enable;
    logic [CW-1:0] count;
    logic          first;
    logic          last;
    logic          busy;
    logic          done;
    logic          rep;

    modport master (
        output start, n_iter, mode, stall,
        input  enable, count, first, last, busy, done, rep
    );

    modport slave (
        input  start, n_iter, mode, stall,
        output enable, count, first, last, busy, done, rep
    );

endinterface

// File: rtl/cordic_rep_tracker.sv
// Hyperbolic repeat tracking: remembers which repeat indices were already
// issued twice and flags the repeated cycle. Used only with CORDIC_HYP_EN.
module cordic_rep_tracker
    import cordic_pkg::*;
#(
    parameter int MAX_ITER = 16,
    parameter int CW       = $clog2(MAX_ITER + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clr,
    input  logic          adv,
    input  logic          hyp,
    input  logic [CW-1:0] count,
    output logic          pending,
    output logic          rep
);

    logic [NREP-1:0] rep_done;
    logic [NREP-1:0] hit;

    assign hit     = rep_hit(int'(count), MAX_ITER) & {NREP{hyp}};
    assign pending = |(hit & ~rep_done);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rep_done <= '0;
            rep      <= 1'b0;
        end else if (clr) begin
            rep_done <= '0;
            rep      <= 1'b0;
        end else if (adv) begin
            if (pending) begin
                rep_done <= rep_done | hit;
                rep      <= 1'b1;
            end else begin
                rep      <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cordic_iter_seq.sv
// CORDIC iteration sequencer: drives ROM address / shift index with stall,
// restart and done handshake. Define CORDIC_HYP_EN for hyperbolic repeats.
module cordic_iter_seq
    import cordic_pkg::*;
#(
    parameter int MAX_ITER = 16,
    parameter int CW       = $clog2(MAX_ITER + 1)
) (
    input  logic              clock,
    input  logic              reset,
    cordic_iter_seq_if.slave  bus
);

    localparam logic [CW-1:0] MAXN = CW'(MAX_ITER);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t        state, state_nx;
    logic [CW-1:0] count, count_nx;
    logic [CW-1:0] n_q, n_nx, n_clamp;
    logic [CW-1:0] base, base_nx, last_idx;
    logic          busy, busy_nx;
    logic          done, done_nx;
    logic          hyp, pending, rep, adv, last;

    assign n_clamp = (bus.n_iter == '0)  ? ONE  :
                     (bus.n_iter > MAXN) ? MAXN : bus.n_iter;

`ifdef CORDIC_HYP_EN
    logic mode_q, mode_nx;

    assign hyp     = (mode_q == MODE_HYP);
    assign base_nx = {{(CW-1){1'b0}}, bus.mode == MODE_HYP};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) mode_q <= MODE_CIRC;
        else        mode_q <= mode_nx;
    end

    always_comb begin
        mode_nx = mode_q;
        if (bus.start) mode_nx = bus.mode;
    end

    cordic_rep_tracker #(
        .MAX_ITER (MAX_ITER),
        .CW       (CW)
    ) u_rep (
        .clock    (clock),
        .reset    (reset),
        .clr      (bus.start),
        .adv      (adv),
        .hyp      (hyp),
        .count    (count),
        .pending  (pending),
        .rep      (rep)
    );
`else
    assign hyp     = 1'b0;
    assign base_nx = '0;
    assign pending = 1'b0;
    assign rep     = 1'b0;
`endif

    assign base     = {{(CW-1){1'b0}}, hyp};
    assign last_idx = base + n_q - ONE;
    assign adv      = busy & ~bus.stall & ~bus.start;
    assign last     = busy & (count == last_idx) & ~pending;

    assign bus.enable = bus.start | (busy & ~bus.stall);
    assign bus.count  = count;
    assign bus.first  = busy & (count == base) & ~rep;
    assign bus.last   = last;
    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.rep    = rep;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            count <= '0;
            n_q   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            n_q   <= n_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        n_nx     = n_q;
        busy_nx  = busy;
        done_nx  = 1'b0;
        if (bus.start) begin
            // A retiring last still completes its run even when restarted
            state_nx = ST_RUN;
            count_nx = base_nx;
            n_nx     = n_clamp;
            busy_nx  = 1'b1;
            done_nx  = last & ~bus.stall;
        end else if (state == ST_RUN && !bus.stall) begin
            if (pending) begin
                count_nx = count;
            end else if (last) begin
                state_nx = ST_IDLE;
                count_nx = '0;
                busy_nx  = 1'b0;
                done_nx  = 1'b1;
            end else begin
                count_nx = count + ONE;
            end
        end
    end

endmodule
